// File: rtl/usb_rx_pkg.sv
// Shared constants for the USB receive path: stream tags, PIDs, CRC16 parameters,
// status-byte bit positions and the framer state encoding.
package usb_rx_pkg;

    localparam int unsigned MAX_PKT_BYTES = 1026;
    localparam int unsigned COUNT_W       = $clog2(MAX_PKT_BYTES + 2);

    localparam logic [7:0] RX_STAT_PID     = 8'd0;
    localparam logic [7:0] RX_STAT_DATA    = 8'd1;
    localparam logic [7:0] RX_STAT_END     = 8'd2;
    localparam logic [7:0] RX_STAT_PID_ERR = 8'd3;

    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;

    // Wire-order (non-reflected) values; the hardware keeps the register bit-reversed.
    localparam logic [15:0] CRC16_POLY     = 16'h8005;
    localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;
    localparam logic [15:0] CRC16_INIT     = 16'hFFFF;

    function automatic logic [15:0] bitRev16(input logic [15:0] v);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) begin
            r[i] = v[15 - i];
        end
        return r;
    endfunction

    localparam logic [15:0] CRC16_POLY_REFL     = bitRev16(CRC16_POLY);
    localparam logic [15:0] CRC16_RESIDUAL_REFL = bitRev16(CRC16_RESIDUAL);

    localparam int unsigned ST_CRC_ERR   = 0;
    localparam int unsigned ST_STUFF_ERR = 1;
    localparam int unsigned ST_NAK       = 3;
    localparam int unsigned ST_STALL     = 4;
    localparam int unsigned ST_ACK       = 5;
    localparam int unsigned ST_DATA1     = 6;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_PID,
        DATA,
        HSHK,
        END_EMIT,
        DISCARD
    } rxState_t;

    function automatic logic pidValid(input logic [7:0] b);
        return b[7:4] == ~b[3:0];
    endfunction

endpackage

// File: rtl/usb_crc16_byte.sv
// One byte of USB CRC16 in reflected form (bits consumed LSB first); purely combinational.
module usb_crc16_byte
    import usb_rx_pkg::*;
(
    input  logic [15:0] crc_in,
    input  logic [7:0]  data_in,
    output logic [15:0] crc_out
);

    logic [15:0] crcWork;

    always_comb begin
        crcWork = crc_in;
        for (int i = 0; i < 8; i++) begin
            if (crcWork[0] ^ data_in[i]) begin
                crcWork = (crcWork >> 1) ^ CRC16_POLY_REFL;
            end else begin
                crcWork = crcWork >> 1;
            end
        end
        crc_out = crcWork;
    end

endmodule

// File: rtl/rx_packet_framer.sv
// Receive packet framer: checks PID and data CRC16, re-emits the packet as a
// tagged byte stream terminated by a status byte.
module rx_packet_framer
    import usb_rx_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       RxPktStart,
    input  logic [7:0] RxByteIn,
    input  logic       RxByteValid,
    input  logic       RxPktEnd,
    input  logic       RxBitStuffErr,
    output logic [7:0] RXDataOut,
    output logic       RXDataValid,
    output logic [7:0] RXStreamStatusOut,
    output logic       FramerBusy
);

    rxState_t           state;
    logic [15:0]        crcReg;
    logic [15:0]        crcNext;
    logic [COUNT_W-1:0] byteCount;
    logic [3:0]         pidReg;
    logic               stuffErr;
    logic               extraByte;
    logic               crcErr;
    logic               handshakeOk;
    logic [7:0]         statusByte;

    usb_crc16_byte uCrc (
        .crc_in  (crcReg),
        .data_in (RxByteIn),
        .crc_out (crcNext)
    );

    // Status byte from the flags as they stand once the packet has ended.
    always_comb begin
        statusByte  = '0;
        crcErr      = (crcReg != CRC16_RESIDUAL_REFL)
                   || (byteCount < COUNT_W'(2))
                   || (byteCount > COUNT_W'(MAX_PKT_BYTES));
        handshakeOk = !extraByte && !stuffErr;
        statusByte[ST_STUFF_ERR] = stuffErr;
        if (pidReg[1:0] == 2'b11) begin
            statusByte[ST_CRC_ERR] = crcErr;
            statusByte[ST_DATA1]   = (pidReg == PID_DATA1);
        end else begin
            statusByte[ST_NAK]   = handshakeOk && (pidReg == PID_NAK);
            statusByte[ST_STALL] = handshakeOk && (pidReg == PID_STALL);
            statusByte[ST_ACK]   = handshakeOk && (pidReg == PID_ACK);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= IDLE;
            crcReg            <= CRC16_INIT;
            byteCount         <= '0;
            pidReg            <= '0;
            stuffErr          <= 1'b0;
            extraByte         <= 1'b0;
            RXDataOut         <= '0;
            RXDataValid       <= 1'b0;
            RXStreamStatusOut <= '0;
            FramerBusy        <= 1'b0;
        end else begin
            RXDataValid <= 1'b0;
            if (RxPktStart) begin
                // A new SYNC always wins, abandoning any packet in flight.
                state      <= WAIT_PID;
                crcReg     <= CRC16_INIT;
                byteCount  <= '0;
                stuffErr   <= 1'b0;
                extraByte  <= 1'b0;
                FramerBusy <= 1'b1;
            end else begin
                if (state != IDLE && RxBitStuffErr) begin
                    stuffErr <= 1'b1;
                end
                case (state)
                    IDLE: begin
                        FramerBusy <= 1'b0;
                    end
                    WAIT_PID: begin
                        if (RxByteValid) begin
                            RXDataOut   <= RxByteIn;
                            RXDataValid <= 1'b1;
                            if (!pidValid(RxByteIn)) begin
                                RXStreamStatusOut <= RX_STAT_PID_ERR;
                                if (RxPktEnd) begin
                                    state      <= IDLE;
                                    FramerBusy <= 1'b0;
                                end else begin
                                    state <= DISCARD;
                                end
                            end else begin
                                RXStreamStatusOut <= RX_STAT_PID;
                                pidReg            <= RxByteIn[3:0];
                                if (RxPktEnd) begin
                                    state <= END_EMIT;
                                end else if (RxByteIn[1:0] == 2'b11) begin
                                    state <= DATA;
                                end else begin
                                    state <= HSHK;
                                end
                            end
                        end else if (RxPktEnd) begin
                            state      <= IDLE;
                            FramerBusy <= 1'b0;
                        end
                    end
                    DATA: begin
                        if (RxByteValid) begin
                            RXDataOut         <= RxByteIn;
                            RXDataValid       <= 1'b1;
                            RXStreamStatusOut <= RX_STAT_DATA;
                            crcReg            <= crcNext;
                            if (byteCount != COUNT_W'(MAX_PKT_BYTES + 1)) begin
                                byteCount <= byteCount + COUNT_W'(1);
                            end
                        end
                        if (RxPktEnd) begin
                            state <= END_EMIT;
                        end
                    end
                    HSHK: begin
                        if (RxByteValid) begin
                            extraByte <= 1'b1;
                        end
                        if (RxPktEnd) begin
                            state <= END_EMIT;
                        end
                    end
                    END_EMIT: begin
                        // Busy stays up through the status cycle and drops in IDLE.
                        RXDataOut         <= statusByte;
                        RXDataValid       <= 1'b1;
                        RXStreamStatusOut <= RX_STAT_END;
                        state             <= IDLE;
                    end
                    DISCARD: begin
                        if (RxPktEnd) begin
                            state      <= IDLE;
                            FramerBusy <= 1'b0;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rx_packet_framer.sv
// Directed bench for rx_packet_framer: a packet-level model predicts the tagged
// stream, a monitor checks every emitted strobe, and literal checks pin the model.
module tb_rx_packet_framer;

    logic       clk = 1'b0;
    logic       rst;
    logic       RxPktStart;
    logic [7:0] RxByteIn;
    logic       RxByteValid;
    logic       RxPktEnd;
    logic       RxBitStuffErr;
    logic [7:0] RXDataOut;
    logic       RXDataValid;
    logic [7:0] RXStreamStatusOut;
    logic       FramerBusy;

    int testsRun    = 0;
    int testsFailed = 0;
    int cycle       = 0;

    logic [7:0]  txBytes[$];
    logic [15:0] expQ[$];
    logic [15:0] gotQ[$];
    int          gotCyc[$];

    rx_packet_framer dut (
        .clk               (clk),
        .rst               (rst),
        .RxPktStart        (RxPktStart),
        .RxByteIn          (RxByteIn),
        .RxByteValid       (RxByteValid),
        .RxPktEnd          (RxPktEnd),
        .RxBitStuffErr     (RxBitStuffErr),
        .RXDataOut         (RXDataOut),
        .RXDataValid       (RXDataValid),
        .RXStreamStatusOut (RXStreamStatusOut),
        .FramerBusy        (FramerBusy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
        end
    endtask

    // Every strobe is matched against the model's prediction, in order.
    always @(negedge clk) begin
        if (!rst && RXDataValid) begin
            gotQ.push_back({RXStreamStatusOut, RXDataOut});
            gotCyc.push_back(cycle);
            if (expQ.size() == 0) begin
                testsRun++;
                testsFailed++;
                $display("FAIL unexpected strobe: got tag %0d byte 0x%02h, required none", RXStreamStatusOut, RXDataOut);
            end else begin
                check("stream byte", {RXStreamStatusOut, RXDataOut}, {16'h0, expQ.pop_front()});
            end
            if (RXStreamStatusOut == 8'd2) begin
                check("busy at status", FramerBusy, 1);
            end
        end
    end

    // Wire-order CRC16 (poly 0x8005, MSB-first register, bits LSB-first per byte).
    function automatic logic [15:0] crcOver(input int n);
        logic [15:0] c = 16'hFFFF;
        logic fb;
        for (int i = 0; i < n; i++) begin
            for (int b = 0; b < 8; b++) begin
                fb = txBytes[i][b] ^ c[15];
                c  = {c[14:0], 1'b0};
                if (fb) c = c ^ 16'h8005;
            end
        end
        return c;
    endfunction

    function automatic void appendCrc();
        logic [15:0] t;
        logic [7:0]  b0;
        logic [7:0]  b1;
        t = ~crcOver(txBytes.size());
        for (int k = 0; k < 8; k++) begin
            b0[k] = t[15 - k];
            b1[k] = t[7 - k];
        end
        txBytes.push_back(b0);
        txBytes.push_back(b1);
    endfunction

    function automatic void modelPacket(input logic [7:0] pidByte, input bit stuff);
        logic [7:0] st = 8'h00;
        bit         crcBad;
        if (pidByte[7:4] != ~pidByte[3:0]) begin
            expQ.push_back({8'd3, pidByte});
            return;
        end
        expQ.push_back({8'd0, pidByte});
        st[1] = stuff;
        if (pidByte[1:0] == 2'b11) begin
            foreach (txBytes[i]) expQ.push_back({8'd1, txBytes[i]});
            crcBad = (crcOver(txBytes.size()) != 16'h800D) || (txBytes.size() < 2) || (txBytes.size() > 1026);
            st[0] = crcBad;
            st[6] = (pidByte[3:0] == 4'hB);
        end else if (txBytes.size() == 0 && !stuff) begin
            st[3] = (pidByte[3:0] == 4'hA);
            st[4] = (pidByte[3:0] == 4'hE);
            st[5] = (pidByte[3:0] == 4'h2);
        end
        expQ.push_back({8'd2, st});
    endfunction

    function automatic logic [15:0] lastGot();
        if (gotQ.size() == 0) return 16'hFFFF;
        return gotQ[gotQ.size() - 1];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // stuffIdx: payload index carrying a bit-stuff pulse, txBytes.size() for the EOP cycle, -1 none.
    task automatic sendPkt(input logic [7:0] pidByte, input int stuffIdx, input bit endWithLast);
        int n = txBytes.size();
        gotQ.delete();
        gotCyc.delete();
        modelPacket(pidByte, stuffIdx >= 0);
        RxPktStart = 1'b1;
        tick();
        RxPktStart = 1'b0;
        check("busy after start", FramerBusy, 1);
        tick();
        RxByteIn    = pidByte;
        RxByteValid = 1'b1;
        if (n == 0 && endWithLast) RxPktEnd = 1'b1;
        if (n == 0 && endWithLast && stuffIdx == 0) RxBitStuffErr = 1'b1;
        tick();
        RxByteValid = 1'b0;
        RxPktEnd = 1'b0;
        RxBitStuffErr = 1'b0;
        tick();
        for (int i = 0; i < n; i++) begin
            RxByteIn    = txBytes[i];
            RxByteValid = 1'b1;
            if (i == stuffIdx) RxBitStuffErr = 1'b1;
            if (i == n - 1 && endWithLast) RxPktEnd = 1'b1;
            tick();
            RxByteValid = 1'b0;
            RxBitStuffErr = 1'b0;
            RxPktEnd = 1'b0;
            tick();
        end
        if (!endWithLast) begin
            RxPktEnd = 1'b1;
            if (stuffIdx == n) RxBitStuffErr = 1'b1;
            tick();
            RxPktEnd = 1'b0;
            RxBitStuffErr = 1'b0;
        end
        repeat (4) tick();
        check("busy idle after packet", FramerBusy, 0);
    endtask

    initial begin
        rst = 1'b1;
        RxPktStart = 1'b0;
        RxByteIn = 8'h00;
        RxByteValid = 1'b0;
        RxPktEnd = 1'b0;
        RxBitStuffErr = 1'b0;
        repeat (3) tick();
        check("reset data", RXDataOut, 0);
        check("reset valid", RXDataValid, 0);
        check("reset tag", RXStreamStatusOut, 0);
        check("reset busy", FramerBusy, 0);
        rst = 1'b0;
        tick();

        txBytes.delete();
        sendPkt(8'hD2, -1, 0);
        check("ack count", gotQ.size(), 2);
        check("ack pid", (gotQ.size() > 0) ? gotQ[0] : 16'hFFFF, 16'h00D2);
        check("ack status", lastGot(), 16'h0220);

        txBytes = '{8'h00, 8'h00};
        sendPkt(8'h4B, -1, 0);
        check("data1 zlp count", gotQ.size(), 4);
        check("data1 zlp status", lastGot(), 16'h0240);

        txBytes = '{8'h01, 8'h02, 8'h03, 8'h04};
        appendCrc();
        sendPkt(8'hC3, -1, 0);
        check("data0 count", gotQ.size(), 8);
        check("data0 good status", lastGot(), 16'h0200);

        txBytes[1] = txBytes[1] ^ 8'h10;
        sendPkt(8'hC3, -1, 0);
        check("data0 flipped status", lastGot(), 16'h0201);

        txBytes = '{8'h11, 8'h22};
        sendPkt(8'hC2, -1, 0);
        check("pid err count", gotQ.size(), 1);
        check("pid err byte", lastGot(), 16'h03C2);

        txBytes = '{8'h77};
        sendPkt(8'h5A, 0, 0);
        check("nak masked status", lastGot(), 16'h0202);

        txBytes.delete();
        sendPkt(8'h1E, -1, 0);
        check("stall status", lastGot(), 16'h0210);

        txBytes.delete();
        sendPkt(8'hD2, 0, 0);
        check("ack stuff at eop", lastGot(), 16'h0202);

        txBytes.delete();
        sendPkt(8'hD2, -1, 1);
        check("ack pid with eop", lastGot(), 16'h0220);

        txBytes = '{8'h05};
        sendPkt(8'hC3, -1, 0);
        check("short data status", lastGot(), 16'h0201);

        txBytes = '{8'hAA, 8'hBB};
        appendCrc();
        sendPkt(8'hC3, -1, 1);
        check("same-cycle eop status", lastGot(), 16'h0200);
        check("same-cycle eop gap", (gotCyc.size() >= 2) ? gotCyc[gotCyc.size() - 1] - gotCyc[gotCyc.size() - 2] : 0, 1);

        txBytes.delete();
        for (int i = 0; i < 1024; i++) txBytes.push_back(8'(i * 37 + 5));
        appendCrc();
        sendPkt(8'h4B, -1, 0);
        check("max size status", lastGot(), 16'h0240);

        txBytes.delete();
        for (int i = 0; i < 1025; i++) txBytes.push_back(8'(i * 37 + 5));
        appendCrc();
        sendPkt(8'hC3, -1, 0);
        check("oversize status", lastGot(), 16'h0201);

        // Restart mid-packet: first packet yields no status byte.
        gotQ.delete();
        expQ.push_back(16'h00C3);
        expQ.push_back(16'h01AA);
        RxPktStart = 1'b1; tick(); RxPktStart = 1'b0; tick();
        RxByteIn = 8'hC3; RxByteValid = 1'b1; tick(); RxByteValid = 1'b0; tick();
        RxByteIn = 8'hAA; RxByteValid = 1'b1; tick(); RxByteValid = 1'b0; tick();
        txBytes.delete();
        sendPkt(8'hD2, -1, 0);
        check("restart ack status", lastGot(), 16'h0220);
        check("restart no stale status", gotQ.size(), 2);

        // Reset in the middle of a data packet.
        expQ.push_back(16'h00C3);
        expQ.push_back(16'h0111);
        RxPktStart = 1'b1; tick(); RxPktStart = 1'b0; tick();
        RxByteIn = 8'hC3; RxByteValid = 1'b1; tick(); RxByteValid = 1'b0; tick();
        RxByteIn = 8'h11; RxByteValid = 1'b1; tick(); RxByteValid = 1'b0; tick();
        rst = 1'b1;
        #2;
        check("midreset data", RXDataOut, 0);
        check("midreset valid", RXDataValid, 0);
        check("midreset tag", RXStreamStatusOut, 0);
        check("midreset busy", FramerBusy, 0);
        tick();
        rst = 1'b0;
        tick();
        txBytes.delete();
        sendPkt(8'hD2, -1, 0);
        check("post-reset ack status", lastGot(), 16'h0220);

        check("all predicted bytes seen", expQ.size(), 0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
